// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and PC-select
// encodings. The core's PC mux decodes Selpc with the same values.
package exc_ctrl_pkg;

    localparam logic [4:0] C0_STATUS = 5'd12;
    localparam logic [4:0] C0_CAUSE  = 5'd13;
    localparam logic [4:0] C0_EPC    = 5'd14;

    localparam int LVL_W    = 4;
    localparam int STATUS_W = 3 * LVL_W;

    // ExcCode field of Cause[3:2]
    typedef enum logic [1:0] {
        EXC_INT    = 2'b00,
        EXC_SYS    = 2'b01,
        EXC_UNIMPL = 2'b10,
        EXC_OV     = 2'b11
    } exc_code_e;

    // PC source select driven to the core
    typedef enum logic [1:0] {
        SEL_NEXT = 2'b00,
        SEL_EPC  = 2'b01,
        SEL_VEC  = 2'b10
    } selpc_e;

    // Status mask bit positions within the active level
    localparam int MSK_INT    = 0;
    localparam int MSK_SYS    = 1;
    localparam int MSK_UNIMPL = 2;
    localparam int MSK_OV     = 3;

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt request.
module exc_ctrl_int_sync (
    input  logic Clk,
    input  logic Rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Two back-to-back flops; a reset drops any request in flight
    always_ff @(posedge Clk) begin
        if (Rst) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Coprocessor 0: Status/Cause/EPC, exception and interrupt redirect of the
// single-cycle core. Redirect/cancel are combinational so they reach the PC
// mux and write enables in the same cycle as the offending instruction.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] VECTOR = 32'h0000_0008
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Pc,
    input  logic [31:0] Pc_next,
    input  logic        Intr,
    input  logic        Ov,
    input  logic        Unimpl,
    input  logic        Syscall,
    input  logic        Mtc0,
    input  logic        Mfc0,
    input  logic        Eret,
    input  logic [4:0]  C0addr,
    input  logic [31:0] Wdata,
    output logic [31:0] Rdata,
    output logic [1:0]  Selpc,
    output logic [31:0] Epc,
    output logic        Cancel,
    output logic        Inta
);

    // The handler address itself lives in the core's PC mux; only its
    // word alignment is checked here.
    if (VECTOR[1:0] != 2'b00) begin : g_bad_vector
        $error("exc_ctrl: VECTOR must be word aligned");
    end

    logic [STATUS_W-1:0] status;
    logic [1:0]          cause;
    logic [31:0]         epc;
    logic                int_s;
    logic                sync_exc;
    logic [1:0]          exc_code;
    logic                int_take;
    logic [LVL_W-1:0]    act;

    exc_ctrl_int_sync u_int_sync (
        .Clk      (Clk),
        .Rst      (Rst),
        .async_in (Intr),
        .sync_out (int_s)
    );

    assign act = status[LVL_W-1:0];
    assign Epc = epc;

    // Masked exception detect with fixed priority Unimpl > Ov > Syscall
    always_comb begin
        sync_exc = 1'b0;
        exc_code = EXC_INT;
        if (Unimpl && act[MSK_UNIMPL]) begin
            sync_exc = 1'b1;
            exc_code = EXC_UNIMPL;
        end else if (Ov && act[MSK_OV]) begin
            sync_exc = 1'b1;
            exc_code = EXC_OV;
        end else if (Syscall && act[MSK_SYS]) begin
            sync_exc = 1'b1;
            exc_code = EXC_SYS;
        end
    end

    // An interrupt yields to a sync exception and is held off a cycle by
    // Eret/Mtc0 so it is judged against the Status they leave behind.
    assign int_take = int_s && act[MSK_INT] && !sync_exc && !Eret && !Mtc0;

    // Redirect and cancel for the current instruction
    always_comb begin
        Cancel = sync_exc;
        if (sync_exc || int_take) Selpc = SEL_VEC;
        else if (Eret)            Selpc = SEL_EPC;
        else                      Selpc = SEL_NEXT;
    end

    // CP0 read port; unmapped numbers read as zero regardless of Mfc0
    always_comb begin
        case (C0addr)
            C0_STATUS: Rdata = {{(32-STATUS_W){1'b0}}, status};
            C0_CAUSE:  Rdata = {28'b0, cause, 2'b00};
            C0_EPC:    Rdata = epc;
            default:   Rdata = 32'b0;
        endcase
    end

    // Register updates: exception beats interrupt beats Eret/Mtc0
    always_ff @(posedge Clk) begin
        if (Rst) begin
            status <= '0;
            cause  <= 2'b00;
            epc    <= 32'b0;
            Inta   <= 1'b0;
        end else begin
            Inta <= int_take;
            if (sync_exc) begin
                epc    <= Pc;
                cause  <= exc_code;
                status <= {status[STATUS_W-LVL_W-1:0], {LVL_W{1'b0}}};
            end else if (int_take) begin
                epc    <= Pc_next;
                cause  <= EXC_INT;
                status <= {status[STATUS_W-LVL_W-1:0], {LVL_W{1'b0}}};
            end else begin
                if (Eret)
                    status <= {{LVL_W{1'b0}}, status[STATUS_W-1:LVL_W]};
                if (Mtc0) begin
                    case (C0addr)
                        C0_STATUS: status <= Wdata[STATUS_W-1:0];
                        C0_CAUSE:  cause  <= Wdata[3:2];
                        C0_EPC:    epc    <= Wdata;
                        default:   ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized scoreboard bench for exc_ctrl against a level-stack model.
module tb_exc_ctrl;

    logic        Clk, Rst;
    logic [31:0] Pc, Pc_next, Wdata, Rdata, Epc;
    logic        Intr, Ov, Unimpl, Syscall, Mtc0, Mfc0, Eret, Cancel, Inta;
    logic [4:0]  C0addr;
    logic [1:0]  Selpc;

    exc_ctrl #(.VECTOR(32'h0000_0008)) dut (
        .Clk(Clk), .Rst(Rst), .Pc(Pc), .Pc_next(Pc_next), .Intr(Intr),
        .Ov(Ov), .Unimpl(Unimpl), .Syscall(Syscall), .Mtc0(Mtc0),
        .Mfc0(Mfc0), .Eret(Eret), .C0addr(C0addr), .Wdata(Wdata),
        .Rdata(Rdata), .Selpc(Selpc), .Epc(Epc), .Cancel(Cancel), .Inta(Inta)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst, intr, ov, unimpl, sys, mtc0, mfc0, eret;
        logic [31:0] pc, pcn, wdata;
        logic [4:0]  addr;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [1:0]  selpc;
        logic        cancel, inta;
        logic [31:0] epc, rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: Status as a stack of three mask levels, lvl[0] active
    logic [3:0]  lvl [3];
    logic [1:0]  m_cause;
    logic [31:0] m_epc;
    logic        m_inta, m_s1, m_s2;

    function automatic void m_reset();
        for (int i = 0; i < 3; i++) lvl[i] = 4'h0;
        m_cause = 2'b00; m_epc = 32'h0; m_inta = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return {20'h0, lvl[2], lvl[1], lvl[0]};
            5'd13:   return {28'h0, m_cause, 2'b00};
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_push();
        lvl[2] = lvl[1]; lvl[1] = lvl[0]; lvl[0] = 4'h0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        s.pc = 32'h100; s.pcn = 32'h104;
        return s;
    endfunction

    // Drive one instruction cycle, queue its expected response, advance model
    task automatic step(input stim_t s);
        exp_t e;
        int   exc;
        logic take;
        @(posedge Clk); #1;
        cyc++;
        Rst = s.rst; Pc = s.pc; Pc_next = s.pcn; Intr = s.intr; Ov = s.ov;
        Unimpl = s.unimpl; Syscall = s.sys; Mtc0 = s.mtc0; Mfc0 = s.mfc0;
        Eret = s.eret; C0addr = s.addr; Wdata = s.wdata;

        exc = -1;
        if (s.unimpl && lvl[0][2])   exc = 2;
        else if (s.ov && lvl[0][3])  exc = 3;
        else if (s.sys && lvl[0][1]) exc = 1;
        take = (exc < 0) && m_s2 && lvl[0][0] && !s.eret && !s.mtc0;

        e.cyc    = cyc;
        e.selpc  = (exc >= 0 || take) ? 2'b10 : (s.eret ? 2'b01 : 2'b00);
        e.cancel = (exc >= 0);
        e.epc    = m_epc;
        e.inta   = m_inta;
        e.rdata  = m_read(s.addr);
        exp_q.push_back(e);

        if (s.rst) begin
            m_reset();
        end else begin
            m_s2 = m_s1; m_s1 = s.intr;
            m_inta = take;
            if (exc >= 0) begin
                m_epc = s.pc; m_cause = exc[1:0]; m_push();
            end else if (take) begin
                m_epc = s.pcn; m_cause = 2'b00; m_push();
            end else begin
                if (s.eret) begin
                    lvl[0] = lvl[1]; lvl[1] = lvl[2]; lvl[2] = 4'h0;
                end
                if (s.mtc0) begin
                    if (s.addr == 5'd12) begin
                        lvl[0] = s.wdata[3:0]; lvl[1] = s.wdata[7:4]; lvl[2] = s.wdata[11:8];
                    end else if (s.addr == 5'd13) m_cause = s.wdata[3:2];
                    else if (s.addr == 5'd14) m_epc = s.wdata;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, c, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a response; compare mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("selpc",  e.cyc, {30'h0, Selpc},  {30'h0, e.selpc});
                chk("cancel", e.cyc, {31'h0, Cancel}, {31'h0, e.cancel});
                chk("epc",    e.cyc, Epc,             e.epc);
                chk("inta",   e.cyc, {31'h0, Inta},   {31'h0, e.inta});
                chk("rdata",  e.cyc, Rdata,           e.rdata);
            end
        end
    end

    initial begin
        stim_t s;
        logic  intr_r;
        int    r;
        Rst = 1'b1; Pc = 0; Pc_next = 0; Intr = 0; Ov = 0; Unimpl = 0; Syscall = 0;
        Mtc0 = 0; Mfc0 = 0; Eret = 0; C0addr = 0; Wdata = 0;
        repeat (2) @(posedge Clk);
        m_reset();

        // Reset readback, including an unmapped register
        s = idle(); s.mfc0 = 1;
        s.addr = 5'd12; step(s);
        s.addr = 5'd13; step(s);
        s.addr = 5'd14; step(s);
        s.addr = 5'd5;  step(s);

        // Enable all level-0 masks, then overflow at 0x40
        s = idle(); s.mtc0 = 1; s.addr = 5'd12; s.wdata = 32'hF; step(s);
        s = idle(); s.ov = 1; s.pc = 32'h40; step(s);
        s = idle(); s.mfc0 = 1; s.addr = 5'd13; step(s);
        s = idle(); s.mfc0 = 1; s.addr = 5'd12; step(s);

        // Eret from the handler restores the previous level
        s = idle(); s.eret = 1; s.mfc0 = 1; s.addr = 5'd12; step(s);
        s = idle(); s.mfc0 = 1; s.addr = 5'd12; step(s);

        // Exception and Mtc0 to EPC together: the write is dropped
        s = idle(); s.ov = 1; s.pc = 32'h5C; s.mtc0 = 1; s.addr = 5'd14;
        s.wdata = 32'hDEAD_BEEF; step(s);
        s = idle(); s.mfc0 = 1; s.addr = 5'd14; step(s);

        // Interrupt-only enable; a masked syscall is ignored
        s = idle(); s.mtc0 = 1; s.addr = 5'd12; s.wdata = 32'h1; step(s);
        s = idle(); s.sys = 1; s.pc = 32'h80; s.mfc0 = 1; s.addr = 5'd12; step(s);

        // External interrupt through the synchronizer, acknowledged, dropped
        s = idle(); s.pcn = 32'h84; s.intr = 1;
        repeat (4) step(s);
        s.intr = 0; step(s);
        s = idle(); s.mfc0 = 1; s.addr = 5'd12; step(s);

        // Interrupt coinciding with Mtc0 is deferred a cycle
        s = idle(); s.mtc0 = 1; s.addr = 5'd12; s.wdata = 32'h011; step(s);
        s = idle(); s.intr = 1; s.pcn = 32'h200; step(s); step(s);
        s.mtc0 = 1; s.addr = 5'd13; s.wdata = 32'h4; step(s);
        s = idle(); s.intr = 1; s.pcn = 32'h300; step(s);
        s.intr = 0; step(s); step(s);

        // Randomized traffic
        intr_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_inta) intr_r = 1'b0;
            else if (!intr_r && $urandom_range(0, 15) == 0) intr_r = 1'b1;
            s = idle();
            s.rst    = ($urandom_range(0, 299) == 0);
            s.intr   = intr_r;
            s.pc     = $urandom; s.pcn = $urandom; s.wdata = $urandom;
            s.ov     = ($urandom_range(0, 7) == 0);
            s.unimpl = ($urandom_range(0, 9) == 0);
            s.sys    = ($urandom_range(0, 7) == 0);
            s.mfc0   = ($urandom_range(0, 1) == 0);
            r = $urandom_range(0, 7);
            s.mtc0   = (r < 2);
            s.eret   = (r == 2);
            r = $urandom_range(0, 4);
            s.addr   = (r == 0) ? 5'd12 : (r == 1) ? 5'd13 : (r == 2) ? 5'd14 : 5'($urandom);
            if (s.rst) intr_r = 1'b0;
            step(s);
        end

        @(negedge Clk); #1;
        chk("queue_drained", cyc, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
